ps2_scancode_decoder: RTL

- Downstream consumer of the PS/2 byte receiver. Takes each received set-2 scancode byte and resolves the E0 (extended), F0 (break) and E1 (pause) prefixes into single key events.
- Buffers events in a small FIFO with a valid/ready pop interface.
- Tracks live modifier-key state for the keyboard front end.

---
 rtl/ps2_scancode_decoder.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_scancode_decoder.sv
// ---------------------------------------------------------------------------
// ps2_scancode_decoder
//
// Turns the set-2 scancode byte stream from the PS/2 byte receiver into
// single key events. E0 (extended), F0 (break) and E1 (pause) prefixes are
// folded into each event. Events are queued in a small FIFO with a
// valid/ready pop interface. Live modifier-key state is tracked alongside.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   reset      synchronous, active-high reset
//   rx_data    scancode byte from the receiver
//   rx_valid   one-cycle strobe qualifying rx_data
//   ev_code    key code of the event at the FIFO head
//   ev_ext     head event carried an E0 prefix
//   ev_break   head event is a release (F0)
//   ev_valid   FIFO not empty
//   ev_ready   consumer pop; an entry pops when ev_valid && ev_ready
//   mod_state  {ralt, lalt, rctrl, lctrl, rshift, lshift}, 1 = held
//   overflow   sticky: an event was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module ps2_scancode_decoder #(
    parameter int FIFO_DEPTH     = 4,       // power of two, >= 2
    parameter int PREFIX_TIMEOUT = 100000   // cycles allowed between sequence bytes
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [5:0] mod_state,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(PREFIX_TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(PREFIX_TIMEOUT - 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } event_t;

    typedef enum logic [2:0] {
        IDLE,
        GOT_E0,
        GOT_F0,
        GOT_E0F0,
        PAUSE_SKIP
    } state_t;

    state_t          state, state_n;
    logic [2:0]      skip_cnt, skip_n;
    logic [TW-1:0]   tmo_cnt, tmo_n;
    logic [5:0]      mod_n;
    logic            emit;
    event_t          emit_ev;

    logic            is_noise, is_prefix;

    // Receiver/keyboard housekeeping bytes that never form key events.
    assign is_noise  = rx_data inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
    assign is_prefix = rx_data inside {8'hE0, 8'hF0, 8'hE1};

    // ------------------------------------------------------------------
    // Prefix FSM: next state, counters and decoded event
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_n = state;
        skip_n  = skip_cnt;
        tmo_n   = '0;
        emit    = 1'b0;
        emit_ev = '0;

        if (rx_valid) begin
            unique case (state)
                IDLE: begin
                    if (rx_data == 8'hE0) begin
                        state_n = GOT_E0;
                    end else if (rx_data == 8'hF0) begin
                        state_n = GOT_F0;
                    end else if (rx_data == 8'hE1) begin
                        state_n = PAUSE_SKIP;
                        skip_n  = 3'd7;   // E1 is followed by seven more bytes
                    end else if (!is_noise) begin
                        emit    = 1'b1;
                        emit_ev = '{ext: 1'b0, brk: 1'b0, code: rx_data};
                    end
                end
                GOT_E0: begin
                    if (rx_data == 8'hF0) begin
                        state_n = GOT_E0F0;
                    end else if (rx_data == 8'hE0) begin
                        state_n = GOT_E0;
                    end else begin
                        state_n = IDLE;
                        // E0 12 is the keyboard's fake shift; swallow it.
                        if (rx_data != 8'h12) begin
                            emit    = 1'b1;
                            emit_ev = '{ext: 1'b1, brk: 1'b0, code: rx_data};
                        end
                    end
                end
                GOT_F0: begin
                    state_n = IDLE;
                    if (!is_prefix) begin
                        emit    = 1'b1;
                        emit_ev = '{ext: 1'b0, brk: 1'b1, code: rx_data};
                    end
                end
                GOT_E0F0: begin
                    state_n = IDLE;
                    if (!is_prefix && rx_data != 8'h12) begin
                        emit    = 1'b1;
                        emit_ev = '{ext: 1'b1, brk: 1'b1, code: rx_data};
                    end
                end
                PAUSE_SKIP: begin
                    skip_n = skip_cnt - 3'd1;
                    if (skip_cnt == 3'd1) begin
                        state_n = IDLE;
                        emit    = 1'b1;
                        emit_ev = '{ext: 1'b1, brk: 1'b0, code: 8'h77};
                    end
                end
                default: state_n = IDLE;
            endcase
        end else if (state != IDLE) begin
            // Abandon a stalled multi-byte sequence without an event.
            if (tmo_cnt == TMO_LAST) begin
                state_n = IDLE;
            end else begin
                tmo_n = tmo_cnt + 1'b1;
            end
        end
    end

    // Modifier tracking follows every decoded event, even one the FIFO drops.
    always_comb begin
        mod_n = mod_state;
        if (emit) begin
            case ({emit_ev.ext, emit_ev.code})
                9'h012:  mod_n[0] = !emit_ev.brk;  // lshift
                9'h059:  mod_n[1] = !emit_ev.brk;  // rshift
                9'h014:  mod_n[2] = !emit_ev.brk;  // lctrl
                9'h114:  mod_n[3] = !emit_ev.brk;  // rctrl
                9'h011:  mod_n[4] = !emit_ev.brk;  // lalt
                9'h111:  mod_n[5] = !emit_ev.brk;  // ralt
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            skip_cnt  <= '0;
            tmo_cnt   <= '0;
            mod_state <= '0;
        end else begin
            state     <= state_n;
            skip_cnt  <= skip_n;
            tmo_cnt   <= tmo_n;
            mod_state <= mod_n;
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    event_t          mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            full, pop, do_write;
    event_t          head;

    assign full     = (count == CNT_FULL);
    assign ev_valid = (count != '0);
    assign pop      = ev_valid && ev_ready;
    // A pop in the same cycle frees the slot, so a push while full still fits.
    assign do_write = emit && (!full || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            if (pop)      rd_ptr <= rd_ptr + 1'b1;
            case ({do_write, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (emit && !do_write) overflow <= 1'b1;
        end
    end

    // NOTE: storage has no reset; the pointers and count define which entries
    // are live, and stale contents are masked off the head outputs.
    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr] <= emit_ev;
    end

    // Head comes straight from storage, forced to zero while empty.
    assign head     = mem[rd_ptr];
    assign ev_code  = ev_valid ? head.code : 8'h00;
    assign ev_ext   = ev_valid && head.ext;
    assign ev_break = ev_valid && head.brk;

endmodule
